shift_seq_ctrl: RTL and testbench

- Sequential controller for the 4-bit shift datapath.
- Accepts one shift request (operand, op, amount) over a valid/ready handshake.
- Executes the shift one bit per clock through a single-step shift stage, then holds the result on a valid/ready output port until it is consumed.
- Sits between a requesting unit and the downstream consumer. One request is in flight at a time.

---
 rtl/shift_pkg.sv | 14 +
 rtl/shift_seq_ctrl_if.sv | 25 ++
 rtl/shift_step.sv | 17 +
 rtl/shift_seq_ctrl.sv | 70 +++++++
 tb/tb_shift_seq_ctrl.sv | 171 +++++++++++++++++
 5 files changed

// File: rtl/shift_pkg.sv
// shift_pkg: shared op codes, FSM state encoding and default widths for the shift datapath
package shift_pkg;
    localparam int WIDTH = 4;
    localparam int AMT_W = 3;
    localparam logic [1:0] OP_LSR = 2'b00;
    localparam logic [1:0] OP_LSL = 2'b01;
    localparam logic [1:0] OP_ASR = 2'b10;
    localparam logic [1:0] OP_ASL = 2'b11;
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;
endpackage

// File: rtl/shift_seq_ctrl_if.sv
// shift_seq_ctrl_if: request and result handshakes of the sequential shift controller
interface shift_seq_ctrl_if
    import shift_pkg::*;
#(
    parameter int WIDTH = shift_pkg::WIDTH,
    parameter int AMT_W = shift_pkg::AMT_W
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic [1:0]       in_op;
    logic [AMT_W-1:0] in_amt;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             busy;
    modport master (
        output in_valid, in_data, in_op, in_amt, out_ready,
        input  in_ready, out_valid, out_data, busy
    );
    modport slave (
        input  in_valid, in_data, in_op, in_amt, out_ready,
        output in_ready, out_valid, out_data, busy
    );
endinterface

// File: rtl/shift_step.sv
// shift_step: combinational single-bit shift of d selected by op
module shift_step
    import shift_pkg::*;
#(
    parameter int WIDTH = shift_pkg::WIDTH
) (
    input  logic [WIDTH-1:0] d,
    input  logic [1:0]       op,
    output logic [WIDTH-1:0] q
);
    // right shifts fill with zero or the sign bit; both left shifts are identical
    always_comb begin
        q = (op == OP_ASR) ? {d[WIDTH-1], d[WIDTH-1:1]} :
            (op == OP_LSR) ? {1'b0, d[WIDTH-1:1]} :
                             {d[WIDTH-2:0], 1'b0};
    end
endmodule

// File: rtl/shift_seq_ctrl.sv
// shift_seq_ctrl: accepts one shift request, steps it one bit per clock, holds the result until consumed
module shift_seq_ctrl
    import shift_pkg::*;
#(
    parameter int WIDTH = shift_pkg::WIDTH,
    parameter int AMT_W = shift_pkg::AMT_W
) (
    input  logic               clk,
    input  logic               rst_n,
    shift_seq_ctrl_if.slave    bus
);
    state_t           state_q, state_d;
    logic [WIDTH-1:0] sh_q, sh_d;
    logic [1:0]       op_q, op_d;
    logic [AMT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] step;

    shift_step #(.WIDTH(WIDTH)) u_step (
        .d  (sh_q),
        .op (op_q),
        .q  (step)
    );

    // state, shift register, op and remaining-step counter
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            sh_q    <= '0;
            op_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sh_q    <= sh_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
        end
    end

    // next state: latch on accept, step while counting down, release on consume
    always_comb begin
        state_d = state_q;
        sh_d    = sh_q;
        op_d    = op_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.in_valid) begin
                    sh_d    = bus.in_data;
                    op_d    = bus.in_op;
                    cnt_d   = bus.in_amt;
                    state_d = (bus.in_amt == '0) ? ST_HOLD : ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                sh_d  = step;
                cnt_d = cnt_q - AMT_W'(1);
                if (cnt_q == AMT_W'(1)) state_d = ST_HOLD;
            end
            ST_HOLD: begin
                if (bus.out_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign bus.in_ready  = (state_q == ST_IDLE);
    assign bus.out_valid = (state_q == ST_HOLD);
    assign bus.out_data  = (state_q == ST_HOLD) ? sh_q : '0;
    assign bus.busy      = (state_q != ST_IDLE);
endmodule

// File: tb/tb_shift_seq_ctrl.sv
// tb_shift_seq_ctrl: directed stimulus with a cycle-level reference model and per-cycle output comparison
module tb_shift_seq_ctrl;
    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   failures = 0;

    shift_seq_ctrl_if bus ();

    shift_seq_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [3:0] shift_ref(input logic [3:0] d, input logic [1:0] op, input int amt);
        logic [3:0] r;
        case (op)
            2'b00:   r = d >> amt;
            2'b10:   r = $signed(d) >>> amt;
            default: r = d << amt;
        endcase
        return r;
    endfunction

    // reference model: a request in flight, the edge after which its result is visible, and the result
    int         ec = 0;
    int         m_vf = 0;
    logic       m_init = 1'b0;
    logic       m_fl = 1'b0;
    logic [3:0] m_res = 4'h0;

    always @(posedge clk) begin
        ec <= ec + 1;
        if (!rst_n) begin
            m_init <= 1'b1;
            m_fl   <= 1'b0;
        end else if (m_init) begin
            if (!m_fl && bus.in_valid) begin
                m_fl  <= 1'b1;
                m_vf  <= ec + int'(bus.in_amt);
                m_res <= shift_ref(bus.in_data, bus.in_op, int'(bus.in_amt));
            end else if (m_fl && ec > m_vf && bus.out_ready) begin
                m_fl <= 1'b0;
            end
        end
    end

    // compare every cycle once reset has been seen
    always @(negedge clk) begin
        if (m_init) begin
            logic ev;
            ev = m_fl && (ec > m_vf);
            chk("cmp_out_valid", 32'(bus.out_valid), 32'(ev));
            chk("cmp_out_data", 32'(bus.out_data), ev ? 32'(m_res) : 32'd0);
            chk("cmp_in_ready", 32'(bus.in_ready), 32'(!m_fl));
            chk("cmp_busy", 32'(bus.busy), 32'(m_fl));
        end
    end

    task automatic xact(input logic [3:0] d, input logic [1:0] op, input logic [2:0] amt,
                        input logic [3:0] exp, input int stall);
        int lat;
        bus.in_valid  = 1'b1;
        bus.in_data   = d;
        bus.in_op     = op;
        bus.in_amt    = amt;
        bus.out_ready = (stall == 0);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.in_data  = 4'($urandom);
        bus.in_op    = 2'($urandom);
        bus.in_amt   = 3'($urandom);
        chk("model_result", 32'(m_res), 32'(exp));
        lat = 0;
        while (!bus.out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("latency", 32'(lat), 32'(amt));
        chk("result", 32'(bus.out_data), 32'(exp));
        chk("busy_in_hold", 32'(bus.busy), 32'd1);
        if (stall > 0) begin
            bus.in_valid = 1'b1;
            bus.in_data  = 4'hF;
            bus.in_amt   = 3'd1;
            repeat (stall) begin
                chk("stall_valid", 32'(bus.out_valid), 32'd1);
                chk("stall_data", 32'(bus.out_data), 32'(exp));
                chk("stall_in_ready", 32'(bus.in_ready), 32'd0);
                @(posedge clk); #1;
            end
            bus.out_ready = 1'b1;
        end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        chk("post_valid", 32'(bus.out_valid), 32'd0);
        chk("post_in_ready", 32'(bus.in_ready), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n         = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_data   = 4'b0110;
        bus.in_op     = 2'b01;
        bus.in_amt    = 3'd0;
        bus.out_ready = 1'b1;
        repeat (2) begin
            @(posedge clk); #1;
            chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
            chk("rst_out_data", 32'(bus.out_data), 32'd0);
            chk("rst_busy", 32'(bus.busy), 32'd0);
        end
        rst_n        = 1'b1;
        bus.in_valid = 1'b0;
        @(posedge clk); #1;
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("rst_no_accept", 32'(bus.busy), 32'd0);

        xact(4'b0101, 2'b00, 3'd1, 4'b0010, 0);
        xact(4'b1001, 2'b01, 3'd1, 4'b0010, 0);
        xact(4'b1010, 2'b10, 3'd1, 4'b1101, 0);
        xact(4'b1111, 2'b11, 3'd1, 4'b1110, 0);
        xact(4'b1001, 2'b10, 3'd6, 4'b1111, 0);
        xact(4'b1111, 2'b00, 3'd7, 4'b0000, 0);
        xact(4'b0101, 2'b01, 3'd4, 4'b0000, 0);
        xact(4'b1010, 2'b11, 3'd0, 4'b1010, 0);
        xact(4'b1010, 2'b00, 3'd2, 4'b0010, 5);

        bus.in_valid = 1'b1;
        bus.in_data  = 4'b1000;
        bus.in_op    = 2'b10;
        bus.in_amt   = 3'd5;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        chk("abort_busy_before", 32'(bus.busy), 32'd1);
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk("abort_busy", 32'(bus.busy), 32'd0);
        chk("abort_out_valid", 32'(bus.out_valid), 32'd0);
        chk("abort_in_ready", 32'(bus.in_ready), 32'd1);
        repeat (6) begin
            @(posedge clk); #1;
            chk("abort_no_result", 32'(bus.out_valid), 32'd0);
        end
        xact(4'b0011, 2'b01, 3'd1, 4'b0110, 0);

        repeat (2) @(posedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
